seg8scan_decoder: RTL and testbench

//  Receive side of the 8-digit multiplexed 7-segment scan interface (i_seg_d/i_seg_com, active-high, one-hot com).

---
 rtl/seg8scan_decoder.sv | 158 +++++++++++++++
 tb/tb_seg8scan_decoder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seg8scan_decoder.sv
// Receive side of an 8-digit multiplexed 7-segment scan bus: qualifies each digit dwell,
// decodes segment patterns back to BCD and publishes a full frame once all 8 digits are seen.
module seg8scan_decoder #(
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 150000
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [7:0]  i_seg_d,
  input  logic [7:0]  i_seg_com,
  output logic [31:0] o_bcd8d,
  output logic [7:0]  o_dot,
  output logic        o_frame_vld,
  output logic        o_seg_err,
  output logic        o_com_err,
  output logic        o_stale
);

  localparam int STAB_W = $clog2(STABLE_CYC + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

  logic [15:0]       samp_q, samp_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic              acc_q, acc_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [7:0]        seen_q, seen_d;
  logic [31:0]       shd_bcd_q, shd_bcd_d;
  logic [7:0]        shd_dot_q, shd_dot_d;
  logic [31:0]       bcd_q, bcd_d;
  logic [7:0]        dot_q, dot_d;
  logic              vld_q, vld_d;
  logic              seg_err_q, seg_err_d;
  logic              com_err_q, com_err_d;
  logic              stale_q, stale_d;

  logic       samp_chg, accept, onehot;
  logic [7:0] com, seg;
  logic [2:0] idx;
  logic [4:0] dec;

  // Returns {undecodable, nibble}; all-dark reads as blank (F) without error.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h3f:   return 5'h00;
      7'h06:   return 5'h01;
      7'h5b:   return 5'h02;
      7'h4f:   return 5'h03;
      7'h66:   return 5'h04;
      7'h6d:   return 5'h05;
      7'h7d:   return 5'h06;
      7'h27:   return 5'h07;
      7'h7f:   return 5'h08;
      7'h6f:   return 5'h09;
      7'h00:   return 5'h0f;
      default: return 5'h1e;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block can infer a latch.
    samp_d    = {i_seg_com, i_seg_d};
    samp_chg  = (samp_d != samp_q);
    com       = samp_q[15:8];
    seg       = samp_q[7:0];
    onehot    = (com != 8'h00) && ((com & (com - 8'd1)) == 8'h00);
    idx       = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (com[k]) idx = 3'(k);
    end
    dec       = seg_decode(seg[6:0]);

    stab_d    = samp_chg ? STAB_W'(1)
              : (stab_q == STAB_W'(STABLE_CYC)) ? stab_q : stab_q + 1'b1;
    accept    = (stab_q == STAB_W'(STABLE_CYC)) && !acc_q;
    acc_d     = samp_chg ? 1'b0 : (accept ? 1'b1 : acc_q);

    seen_d    = seen_q;
    shd_bcd_d = shd_bcd_q;
    shd_dot_d = shd_dot_q;
    bcd_d     = bcd_q;
    dot_d     = dot_q;
    vld_d     = 1'b0;
    seg_err_d = 1'b0;
    com_err_d = 1'b0;
    stale_d   = stale_q;
    tmo_d     = tmo_q;

    if (accept) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_W'(TIMEOUT_CYC)) begin
      tmo_d = tmo_q + 1'b1;
      // The single cycle the counter lands on the limit abandons the partial frame.
      if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        seen_d  = 8'h00;
        stale_d = 1'b1;
      end
    end

    if (accept && onehot) begin
      shd_bcd_d[int'(idx)*4 +: 4] = dec[3:0];
      shd_dot_d[idx]              = seg[7];
      seg_err_d                   = dec[4];
      if ((seen_q | (8'h01 << idx)) == 8'hff) begin
        bcd_d   = shd_bcd_d;
        dot_d   = shd_dot_d;
        vld_d   = 1'b1;
        stale_d = 1'b0;
        seen_d  = 8'h00;
      end else begin
        seen_d  = seen_q | (8'h01 << idx);
      end
    end else if (accept && com != 8'h00) begin
      com_err_d = 1'b1;
    end
  end

  // NOTE: the shadow frame is reset like any other register so a mid-frame reset cannot leak old digits.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      samp_q    <= '0;
      stab_q    <= '0;
      acc_q     <= 1'b0;
      tmo_q     <= '0;
      seen_q    <= '0;
      shd_bcd_q <= '0;
      shd_dot_q <= '0;
      bcd_q     <= '0;
      dot_q     <= '0;
      vld_q     <= 1'b0;
      seg_err_q <= 1'b0;
      com_err_q <= 1'b0;
      stale_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the pre-edge value of its peers.
      samp_q    <= samp_d;
      stab_q    <= stab_d;
      acc_q     <= acc_d;
      tmo_q     <= tmo_d;
      seen_q    <= seen_d;
      shd_bcd_q <= shd_bcd_d;
      shd_dot_q <= shd_dot_d;
      bcd_q     <= bcd_d;
      dot_q     <= dot_d;
      vld_q     <= vld_d;
      seg_err_q <= seg_err_d;
      com_err_q <= com_err_d;
      stale_q   <= stale_d;
    end
  end

  assign o_bcd8d     = bcd_q;
  assign o_dot       = dot_q;
  assign o_frame_vld = vld_q;
  assign o_seg_err   = seg_err_q;
  assign o_com_err   = com_err_q;
  assign o_stale     = stale_q;

endmodule

// File: tb/tb_seg8scan_decoder.sv
// Directed bench for seg8scan_decoder: table of scanned frames plus hand-written
// sequences for glitches, com errors, timeout and mid-scan reset.
module tb_seg8scan_decoder;

  localparam int STABLE_CYC  = 4;
  localparam int TIMEOUT_CYC = 40;
  localparam int PERIOD      = 10;

  logic        clk;
  logic        rst_n;
  logic [7:0]  seg_d;
  logic [7:0]  seg_com;
  logic [31:0] bcd8d;
  logic [7:0]  dot;
  logic        frame_vld;
  logic        seg_err;
  logic        com_err;
  logic        stale;

  seg8scan_decoder #(.STABLE_CYC(STABLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .i_clk      (clk),
    .i_rstn     (rst_n),
    .i_seg_d    (seg_d),
    .i_seg_com  (seg_com),
    .o_bcd8d    (bcd8d),
    .o_dot      (dot),
    .o_frame_vld(frame_vld),
    .o_seg_err  (seg_err),
    .o_com_err  (com_err),
    .o_stale    (stale)
  );

  initial clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  typedef struct {
    logic [7:0][7:0] segs;
    bit              asc;
    logic [31:0]     exp_bcd;
    logic [7:0]      exp_dot;
    int              exp_seg_err;
  } frame_vec_t;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  vld_cnt, seg_err_cnt, com_err_cnt;
  time vld_time, frame_set_t, last_set;

  always @(negedge clk) begin
    if (frame_vld) begin
      vld_cnt++;
      vld_time = $time;
    end
    if (seg_err) seg_err_cnt++;
    if (com_err) com_err_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3f;  4'd1: return 7'h06;  4'd2: return 7'h5b;
      4'd3: return 7'h4f;  4'd4: return 7'h66;  4'd5: return 7'h6d;
      4'd6: return 7'h7d;  4'd7: return 7'h27;  4'd8: return 7'h7f;
      4'd9: return 7'h6f;  default: return 7'h00;
    endcase
  endfunction

  function automatic logic [7:0][7:0] mk(input logic [31:0] digits, input logic [7:0] dots);
    logic [7:0][7:0] s;
    for (int k = 0; k < 8; k++) s[k] = {dots[k], seg_of(digits[k*4 +: 4])};
    return s;
  endfunction

  task automatic send_digit(input logic [7:0] c, input logic [7:0] s, input int n);
    seg_com  = c;
    seg_d    = s;
    last_set = $time;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [7:0][7:0] segs, input bit asc, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      int k;
      k = asc ? i : 7 - i;
      send_digit(8'h01 << k, segs[k], 10);
      frame_set_t = last_set;
    end
  endtask

  task automatic clear_mon();
    @(posedge clk);
    #1;
    vld_cnt     = 0;
    seg_err_cnt = 0;
    com_err_cnt = 0;
    @(negedge clk);
  endtask

  frame_vec_t vecs[5];

  initial begin
    logic [7:0][7:0] s;

    vecs[0] = '{mk(32'h12345678, 8'h00), 1'b0, 32'h12345678, 8'h00, 0};
    vecs[1] = '{mk(32'h12345678, 8'h08), 1'b1, 32'h12345678, 8'h08, 0};
    s = mk(32'h12345678, 8'h00);
    s[5] = 8'h11;
    s[2] = 8'h00;
    vecs[2] = '{s, 1'b0, 32'h12E45F78, 8'h00, 1};
    vecs[3] = '{mk(32'h90817263, 8'hA5), 1'b1, 32'h90817263, 8'hA5, 0};
    s = mk(32'h12345678, 8'h01);
    s[0] = 8'h91;
    vecs[4] = '{s, 1'b0, 32'h1234567E, 8'h01, 1};

    rst_n = 1'b0;
    seg_com = 8'h00;
    seg_d = 8'h00;
    vld_cnt = 0; seg_err_cnt = 0; com_err_cnt = 0;
    repeat (3) @(negedge clk);
    check("reset_bcd", bcd8d, 32'h0);
    check("reset_dot", {24'h0, dot}, 32'h0);
    check("reset_stale", {31'h0, stale}, 32'h1);
    check("reset_vld", {31'h0, frame_vld}, 32'h0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("idle_stale", {31'h0, stale}, 32'h1);

    for (int v = 0; v < 5; v++) begin
      clear_mon();
      scan(vecs[v].segs, vecs[v].asc, 0, 7);
      send_digit(8'h00, 8'h00, 12);
      check($sformatf("v%0d_vld_cnt", v), vld_cnt, 1);
      check($sformatf("v%0d_bcd", v), bcd8d, vecs[v].exp_bcd);
      check($sformatf("v%0d_dot", v), {24'h0, dot}, {24'h0, vecs[v].exp_dot});
      check($sformatf("v%0d_seg_err", v), seg_err_cnt, vecs[v].exp_seg_err);
      check($sformatf("v%0d_com_err", v), com_err_cnt, 0);
      check($sformatf("v%0d_stale", v), {31'h0, stale}, 32'h0);
      check($sformatf("v%0d_latency", v), 32'(vld_time - frame_set_t), (STABLE_CYC + 1) * PERIOD);
    end

    // Glitch to digit0 shorter than the qualify window must not be accepted.
    clear_mon();
    s = mk(32'h31415926, 8'h00);
    send_digit(8'h80, s[7], 2);
    send_digit(8'h01, {1'b0, seg_of(4'd9)}, STABLE_CYC - 1);
    send_digit(8'h80, s[7], 10);
    scan(s, 1'b0, 1, 6);
    send_digit(8'h01, s[0], STABLE_CYC);
    frame_set_t = last_set;
    send_digit(8'h00, 8'h00, 12);
    check("glitch_vld_cnt", vld_cnt, 1);
    check("glitch_bcd", bcd8d, 32'h31415926);
    check("glitch_latency", 32'(vld_time - frame_set_t), (STABLE_CYC + 1) * PERIOD);

    // Non-one-hot com: one error pulse, no shadow write, seen mask kept.
    clear_mon();
    s = mk(32'h87654321, 8'h00);
    scan(s, 1'b0, 0, 6);
    send_digit(8'h18, {1'b0, seg_of(4'd0)}, 10);
    check("comerr_cnt", com_err_cnt, 1);
    check("comerr_no_frame", vld_cnt, 0);
    scan(s, 1'b0, 7, 7);
    send_digit(8'h00, 8'h00, 12);
    check("comerr_vld_cnt", vld_cnt, 1);
    check("comerr_bcd", bcd8d, 32'h87654321);
    check("comerr_seg_err", seg_err_cnt, 0);

    // Partial frame then static idle longer than the timeout.
    clear_mon();
    s = mk(32'h24681357, 8'h00);
    scan(s, 1'b0, 0, 3);
    send_digit(8'h00, 8'h00, 30);
    check("tmo_not_yet", {31'h0, stale}, 32'h0);
    send_digit(8'h00, 8'h00, 30);
    check("tmo_stale", {31'h0, stale}, 32'h1);
    check("tmo_bcd_kept", bcd8d, 32'h87654321);
    scan(s, 1'b0, 4, 7);
    send_digit(8'h00, 8'h00, 12);
    check("tmo_mask_cleared", vld_cnt, 0);
    scan(s, 1'b0, 0, 7);
    send_digit(8'h00, 8'h00, 12);
    check("tmo_recover_vld", vld_cnt, 1);
    check("tmo_recover_bcd", bcd8d, 32'h24681357);
    check("tmo_recover_stale", {31'h0, stale}, 32'h0);

    // Reset in the middle of a scan discards the partial frame.
    clear_mon();
    s = mk(32'h55667788, 8'h00);
    scan(s, 1'b0, 0, 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_bcd", bcd8d, 32'h0);
    check("mid_rst_dot", {24'h0, dot}, 32'h0);
    check("mid_rst_stale", {31'h0, stale}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    scan(s, 1'b0, 3, 7);
    send_digit(8'h00, 8'h00, 12);
    check("mid_rst_partial", vld_cnt, 0);
    check("mid_rst_stale_hold", {31'h0, stale}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
